// File: rtl/vx_scatter_unit.sv
// Routes full-warp instructions from issue slots to execution blocks, splitting
// each into NUM_LANES-wide packets (pid/sop/eop) behind a 2-entry output buffer.
module vx_scatter_unit #(
  parameter int BLOCK_SIZE = 1,
  parameter int ISSUE_CNT  = 4,
  parameter int THREAD_CNT = 4,
  parameter int NUM_LANES  = THREAD_CNT,
  parameter int WARP_CNT   = 4,
  parameter int NUM_SRCS   = 3,
  parameter int HDR_W      = 64,
  parameter int XLEN       = 32,
  parameter int UUID_W     = 44,
  localparam int WID_W     = (WARP_CNT > 1) ? $clog2(WARP_CNT) : 1,
  localparam int NUM_PKTS  = THREAD_CNT / NUM_LANES,
  localparam int PID_W     = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1
) (
  input  logic                                                      clk,
  input  logic                                                      reset,
  input  logic [ISSUE_CNT-1:0]                                      in_valid,
  input  logic [ISSUE_CNT-1:0][UUID_W-1:0]                          in_uuid,
  input  logic [ISSUE_CNT-1:0][WID_W-1:0]                           in_wid,
  input  logic [ISSUE_CNT-1:0][THREAD_CNT-1:0]                      in_tmask,
  input  logic [ISSUE_CNT-1:0][HDR_W-1:0]                           in_hdr,
  input  logic [ISSUE_CNT-1:0][NUM_SRCS-1:0][THREAD_CNT-1:0][XLEN-1:0] in_src,
  output logic [ISSUE_CNT-1:0]                                      in_ready,
  output logic [BLOCK_SIZE-1:0]                                     out_valid,
  output logic [BLOCK_SIZE-1:0][UUID_W-1:0]                         out_uuid,
  output logic [BLOCK_SIZE-1:0][WID_W-1:0]                          out_wid,
  output logic [BLOCK_SIZE-1:0][HDR_W-1:0]                          out_hdr,
  output logic [BLOCK_SIZE-1:0][NUM_LANES-1:0]                      out_tmask,
  output logic [BLOCK_SIZE-1:0][NUM_SRCS-1:0][NUM_LANES-1:0][XLEN-1:0] out_src,
  output logic [BLOCK_SIZE-1:0][PID_W-1:0]                          out_pid,
  output logic [BLOCK_SIZE-1:0]                                     out_sop,
  output logic [BLOCK_SIZE-1:0]                                     out_eop,
  input  logic [BLOCK_SIZE-1:0]                                     out_ready
);

  localparam int NUM_CAND = ISSUE_CNT / BLOCK_SIZE;
  localparam int CAND_W   = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;
  localparam int SRC_W    = NUM_SRCS * NUM_LANES * XLEN;
  localparam int PKT_W    = UUID_W + WID_W + HDR_W + NUM_LANES + SRC_W + PID_W + 2;

  typedef logic [NUM_SRCS-1:0][NUM_LANES-1:0][XLEN-1:0] lane_src_t;

  for (genvar gi = 0; gi < BLOCK_SIZE; gi++) begin : g_blk
    logic                  lock_reg;
    logic [CAND_W-1:0]     grant_reg;
    logic [CAND_W-1:0]     rr_reg;
    logic [PID_W-1:0]      pid_reg;
    logic [PKT_W-1:0]      buf_mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;

    logic                  arb_found;
    logic [CAND_W-1:0]     arb_idx;
    logic [CAND_W-1:0]     sel_idx;
    int                    sel_slot;
    logic                  sel_valid;
    logic [THREAD_CNT-1:0] sel_tmask;
    logic [NUM_PKTS-1:0]   act;
    logic [PID_W-1:0]      first_pid;
    logic [PID_W-1:0]      cur_pid;
    logic [PID_W-1:0]      next_pid;
    logic                  has_next;
    logic                  eop;
    logic [NUM_LANES-1:0]  pkt_tmask;
    lane_src_t             pkt_src;
    logic [PKT_W-1:0]      pkt;
    logic                  enq;
    logic                  deq;

    // Round-robin search starting at rr_reg over this block's candidate slots.
    always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      for (int k = 0; k < NUM_CAND; k++) begin
        if (!arb_found && in_valid[((int'(rr_reg) + k) % NUM_CAND) * BLOCK_SIZE + gi]) begin
          arb_found = 1'b1;
          arb_idx   = CAND_W'((int'(rr_reg) + k) % NUM_CAND);
        end
      end
    end

    always_comb begin
      sel_idx   = lock_reg ? grant_reg : arb_idx;
      sel_slot  = int'(sel_idx) * BLOCK_SIZE + gi;
      sel_valid = lock_reg ? in_valid[sel_slot] : arb_found;
      sel_tmask = in_tmask[sel_slot];

      for (int p = 0; p < NUM_PKTS; p++) begin
        act[p] = |sel_tmask[p*NUM_LANES +: NUM_LANES];
      end

      // An all-zero mask falls through to pid 0 with no successor: one sop/eop packet.
      first_pid = '0;
      for (int p = NUM_PKTS - 1; p >= 0; p--) begin
        if (act[p]) first_pid = PID_W'(p);
      end
      cur_pid = lock_reg ? pid_reg : first_pid;

      has_next = 1'b0;
      next_pid = cur_pid;
      for (int p = NUM_PKTS - 1; p >= 0; p--) begin
        if (act[p] && (p > int'(cur_pid))) begin
          has_next = 1'b1;
          next_pid = PID_W'(p);
        end
      end
      eop = !has_next;

      pkt_tmask = sel_tmask[int'(cur_pid)*NUM_LANES +: NUM_LANES];
      for (int s = 0; s < NUM_SRCS; s++) begin
        for (int l = 0; l < NUM_LANES; l++) begin
          pkt_src[s][l] = in_src[sel_slot][s][int'(cur_pid)*NUM_LANES + l];
        end
      end

      pkt = {in_uuid[sel_slot], in_wid[sel_slot], in_hdr[sel_slot], pkt_tmask, pkt_src,
             cur_pid, !lock_reg, eop};
    end

    assign enq = sel_valid && (count != 2'd2);
    assign deq = (count != 2'd0) && out_ready[gi];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        lock_reg  <= 1'b0;
        grant_reg <= '0;
        rr_reg    <= '0;
        pid_reg   <= '0;
        wr_ptr    <= 1'b0;
        rd_ptr    <= 1'b0;
        count     <= 2'd0;
      end else begin
        if (enq) begin
          wr_ptr <= ~wr_ptr;
          if (eop) begin
            lock_reg <= 1'b0;
            rr_reg   <= (sel_idx == CAND_W'(NUM_CAND - 1)) ? '0 : sel_idx + 1'b1;
          end else begin
            lock_reg  <= 1'b1;
            grant_reg <= sel_idx;
            pid_reg   <= next_pid;
          end
        end
        if (deq) rd_ptr <= ~rd_ptr;
        count <= count + {1'b0, enq} - {1'b0, deq};
      end
    end

    // Payload storage needs no reset: out_valid masks it until written.
    always_ff @(posedge clk) begin
      if (enq) buf_mem[wr_ptr] <= pkt;
    end

    for (genvar gc = 0; gc < NUM_CAND; gc++) begin : g_rdy
      assign in_ready[gc*BLOCK_SIZE + gi] = enq && eop && (sel_idx == CAND_W'(gc));
    end

    assign out_valid[gi] = (count != 2'd0);
    assign {out_uuid[gi], out_wid[gi], out_hdr[gi], out_tmask[gi], out_src[gi],
            out_pid[gi], out_sop[gi], out_eop[gi]} = buf_mem[rd_ptr];
  end

endmodule
